// File: rtl/riscv_irq_arbiter.sv
// riscv_irq_arbiter
//   Front end of the core interrupt controller. Captures external interrupt
//   lines (each one level- or edge-sensitive), masks them, and picks the
//   highest pending index. The chosen request is locked and presented on
//   irq_o / irq_id_o / irq_sec_o. It stays stable until the core acknowledges
//   that id or the request is withdrawn.
module riscv_irq_arbiter #(
    parameter int N_IRQ       = 32,
    parameter int PULP_SECURE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_lines_i,
    input  logic [N_IRQ-1:0] irq_edge_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    input  logic [N_IRQ-1:0] sec_mask_i,
    input  logic             irq_ack_i,
    input  logic [4:0]       irq_ack_id_i,
    output logic             irq_o,
    output logic [4:0]       irq_id_o,
    output logic             irq_sec_o
);

    // Two-state request FSM: idle (arbitrating) or holding a locked request.
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    // ------------------------------------------------------------------
    // Capture state
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] prev_q;      // lines as seen last cycle, for edge detection
    logic [N_IRQ-1:0] pending_q;   // captured requests
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] edge_set;    // rising edge seen this cycle
    logic [N_IRQ-1:0] ack_clr;     // one-hot decode of the acknowledged id
    logic [N_IRQ-1:0] eligible;    // pending and enabled

    // Id-indexed views padded to the full 5-bit id space, so the locked id
    // can index them without width mismatches for any N_IRQ.
    logic [31:0]      eligible_pad;
    logic [31:0]      sec_pad;

    // ------------------------------------------------------------------
    // Arbitration / FSM state
    // ------------------------------------------------------------------
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [4:0]       id_q;
    logic [4:0]       id_d;
    logic             sec_q;
    logic             sec_d;
    logic [4:0]       winner;
    logic             ack_hit;     // ack matches the locked request

    assign edge_set = irq_lines_i & ~prev_q;
    assign eligible = pending_q & irq_mask_i;

    // Decode the ack id into a per-line clear. Ids >= N_IRQ match no line
    // and therefore have no effect.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        ack_clr = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (irq_ack_i && (irq_ack_id_i == 5'(k))) begin
                ack_clr[k] = 1'b1;
            end
        end
    end

    // Next pending value: edge lines set on a rising edge and clear on ack,
    // with set winning so an edge arriving with its own ack is not lost.
    // Level lines simply follow the raw line; the source deasserts them.
    always_comb begin
        pending_d = (irq_edge_i  & (edge_set | (pending_q & ~ack_clr)))
                  | (~irq_edge_i & irq_lines_i);
    end

    // Zero-extend the per-line vectors into the full 32-entry id space.
    always_comb begin
        eligible_pad              = '0;
        eligible_pad[N_IRQ-1:0]   = eligible;
        sec_pad                   = '0;
        sec_pad[N_IRQ-1:0]        = sec_mask_i;
    end

    // Fixed-priority encoder: highest eligible index wins, 0 when none.
    always_comb begin
        winner = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (eligible[k]) begin
                winner = 5'(k);
            end
        end
    end

    assign ack_hit = irq_ack_i && (irq_ack_id_i == id_q);

    // Request FSM: lock the winner from IDLE, release it on its ack or when
    // it stops being eligible. Higher-priority arrivals never preempt.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = REQ;
                    id_d    = winner;
                    sec_d   = (PULP_SECURE != 0) ? sec_pad[winner] : 1'b0;
                end
            end
            REQ: begin
                if (ack_hit) begin
                    // Core took it; the pending bit is cleared in parallel.
                    state_d = IDLE;
                end else if (!eligible_pad[id_q]) begin
                    // Level withdrawn or masked: drop the request unacked.
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture registers: edge history and pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values regardless of block order.
            prev_q    <= irq_lines_i;
            pending_q <= pending_d;
        end
    end

    // FSM and locked-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= '0;
            sec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            sec_q   <= sec_d;
        end
    end

    // Outputs come straight from registers, so they are glitch-free and
    // constant for the whole time the request is held.
    assign irq_o     = (state_q == REQ);
    assign irq_id_o  = id_q;
    assign irq_sec_o = sec_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// tb_riscv_irq_arbiter
//   Directed bench for riscv_irq_arbiter (N_IRQ=32, PULP_SECURE=1).
//   A table of one-cycle vectors covers capture, priority, no-preemption,
//   set-beats-ack and foreign-id acks; short hand-written sequences cover
//   withdrawal, masking and reset in the middle of a request.
module tb_riscv_irq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] irq_lines;
    logic [31:0] irq_edge;
    logic [31:0] irq_mask;
    logic [31:0] sec_mask;
    logic        irq_ack;
    logic [4:0]  irq_ack_id;
    logic        irq_o;
    logic [4:0]  irq_id;
    logic        irq_sec;

    int checks   = 0;
    int failures = 0;

    riscv_irq_arbiter #(
        .N_IRQ       (32),
        .PULP_SECURE (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_lines_i  (irq_lines),
        .irq_edge_i   (irq_edge),
        .irq_mask_i   (irq_mask),
        .sec_mask_i   (sec_mask),
        .irq_ack_i    (irq_ack),
        .irq_ack_id_i (irq_ack_id),
        .irq_o        (irq_o),
        .irq_id_o     (irq_id),
        .irq_sec_o    (irq_sec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One vector = inputs held for one cycle, outputs expected after the edge.
    typedef struct {
        string       name;
        logic [31:0] lines;
        logic        ack;
        logic [4:0]  ack_id;
        logic        exp_irq;
        logic [4:0]  exp_id;
        logic        exp_sec;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] b(input int k);
        logic [31:0] one;
        one = 32'h1;
        return one << k;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] lines,
                                input logic ack, input logic [4:0] ack_id,
                                input logic exp_irq, input logic [4:0] exp_id,
                                input logic exp_sec);
        vec_t v;
        v.name    = name;
        v.lines   = lines;
        v.ack     = ack;
        v.ack_id  = ack_id;
        v.exp_irq = exp_irq;
        v.exp_id  = exp_id;
        v.exp_sec = exp_sec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Lines 5, 7, 12, 20 are edge-sensitive; everything else is level.
        irq_edge   = b(5) | b(7) | b(12) | b(20);
        sec_mask   = b(12);
        irq_mask   = '1;
        irq_lines  = '0;
        irq_ack    = 1'b0;
        irq_ack_id = '0;
        rst_n      = 1'b0;

        // ---------------- table ----------------
        //                 name             lines            ack  id  irq id  sec
        // Edge on line 5: request two cycles after the pulse, ack clears it.
        vecs.push_back(mk("e5_capture",   b(5),            0, 0,  0, 0,  0));
        vecs.push_back(mk("e5_request",   '0,              0, 0,  1, 5,  0));
        vecs.push_back(mk("e5_ack",       '0,              1, 5,  0, 0,  0));
        vecs.push_back(mk("e5_cleared",   '0,              0, 0,  0, 0,  0));
        // Level 3 and 9: 9 wins; ack 9 with line 9 dropped, then 3.
        vecs.push_back(mk("l39_capture",  b(3) | b(9),     0, 0,  0, 0,  0));
        vecs.push_back(mk("l39_pick9",    b(3) | b(9),     0, 0,  1, 9,  0));
        vecs.push_back(mk("l39_ack9",     b(3),            1, 9,  0, 0,  0));
        vecs.push_back(mk("l39_pick3",    b(3),            0, 0,  1, 3,  0));
        // Edge on 20 while holding 3: no preemption until the ack.
        vecs.push_back(mk("np_edge20",    b(3) | b(20),    0, 0,  1, 3,  0));
        vecs.push_back(mk("np_hold3",     b(3),            0, 0,  1, 3,  0));
        vecs.push_back(mk("np_ack3",      b(3),            1, 3,  0, 0,  0));
        vecs.push_back(mk("np_pick20",    b(3),            0, 0,  1, 20, 0));
        vecs.push_back(mk("np_ack20",     '0,              1, 20, 0, 0,  0));
        vecs.push_back(mk("np_quiet",     '0,              0, 0,  0, 0,  0));
        // Edge on 7 coinciding with the ack of 7: set wins, re-request.
        vecs.push_back(mk("e7_capture",   b(7),            0, 0,  0, 0,  0));
        vecs.push_back(mk("e7_request",   '0,              0, 0,  1, 7,  0));
        vecs.push_back(mk("e7_ack_edge",  b(7),            1, 7,  0, 0,  0));
        vecs.push_back(mk("e7_rerequest", '0,              0, 0,  1, 7,  0));
        vecs.push_back(mk("e7_ack",       '0,              1, 7,  0, 0,  0));
        vecs.push_back(mk("e7_cleared",   '0,              0, 0,  0, 0,  0));
        // Secure line 12; a foreign ack (id 5) clears 5 but keeps REQ on 12.
        vecs.push_back(mk("s12_capture",  b(12),           0, 0,  0, 0,  0));
        vecs.push_back(mk("s12_request",  '0,              0, 0,  1, 12, 1));
        vecs.push_back(mk("s12_edge5",    b(5),            0, 0,  1, 12, 1));
        vecs.push_back(mk("s12_ack5",     '0,              1, 5,  1, 12, 1));
        vecs.push_back(mk("s12_ack12",    '0,              1, 12, 0, 0,  0));
        vecs.push_back(mk("s12_no5",      '0,              0, 0,  0, 0,  0));

        // ---------------- reset state ----------------
        step();
        step();
        rst_n = 1'b1;
        check("reset_irq", irq_o, 1'b0);
        check("reset_id",  irq_id, 5'd0);
        check("reset_sec", irq_sec, 1'b0);

        // ---------------- table-driven run ----------------
        foreach (vecs[i]) begin
            irq_lines  = vecs[i].lines;
            irq_ack    = vecs[i].ack;
            irq_ack_id = vecs[i].ack_id;
            step();
            check($sformatf("%s_irq", vecs[i].name), irq_o, vecs[i].exp_irq);
            if (vecs[i].exp_irq) begin
                check($sformatf("%s_id", vecs[i].name), irq_id, vecs[i].exp_id);
                check($sformatf("%s_sec", vecs[i].name), irq_sec, vecs[i].exp_sec);
            end
        end
        irq_lines = '0;
        irq_ack   = 1'b0;
        step();

        // ---------------- level withdrawal ----------------
        irq_lines = b(4);
        step();
        step();
        check("wd_req_irq", irq_o, 1'b1);
        check("wd_req_id",  irq_id, 5'd4);
        irq_lines = '0;
        step();
        step();
        check("wd_dropped", irq_o, 1'b0);
        step();
        check("wd_stays_idle", irq_o, 1'b0);

        // ---------------- mask withdrawal, pending kept ----------------
        irq_lines = b(4);
        step();
        step();
        check("mk_req_irq", irq_o, 1'b1);
        check("mk_req_id",  irq_id, 5'd4);
        irq_mask = ~b(4);
        step();
        check("mk_dropped", irq_o, 1'b0);
        step();
        check("mk_blocked", irq_o, 1'b0);
        irq_mask = '1;
        step();
        check("mk_restored_irq", irq_o, 1'b1);
        check("mk_restored_id",  irq_id, 5'd4);
        irq_lines  = '0;
        irq_ack    = 1'b1;
        irq_ack_id = 5'd4;
        step();
        irq_ack = 1'b0;
        check("mk_acked", irq_o, 1'b0);
        step();

        // ---------------- reset in the middle of a request ----------------
        irq_lines = b(12);
        step();
        irq_lines = '0;
        step();
        check("rs_req_irq", irq_o, 1'b1);
        check("rs_req_id",  irq_id, 5'd12);
        check("rs_req_sec", irq_sec, 1'b1);
        irq_lines = b(20);
        step();
        irq_lines = '0;
        rst_n = 1'b0;
        #1;
        check("rs_async_irq", irq_o, 1'b0);
        check("rs_async_id",  irq_id, 5'd0);
        check("rs_async_sec", irq_sec, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("rs_edges_lost", irq_o, 1'b0);
        step();
        check("rs_still_idle", irq_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
